cic_sample_buffer: RTL and testbench

- Downstream stage of the third-order CIC decimator.
- Captures each decimated CIC output word on a one-cycle strobe and optionally block-averages 1/2/4/8 consecutive words.
- Queues the results in a small show-ahead FIFO, which the readout / serial-interface logic drains through a valid/ready handshake.
- Reports FIFO occupancy, a sticky overflow flag and a running count of queued words.

---
 rtl/cic_sample_buffer.sv | 121 ++++++++++++
 tb/tb_cic_sample_buffer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/cic_sample_buffer.sv
// Captures decimated CIC words, optionally block-averages 1/2/4/8 of them,
// and queues the results in a show-ahead FIFO drained by a valid/ready handshake.
`timescale 1ns/1ps
module cic_sample_buffer #(
  parameter int DATA_WIDTH  = 25,
  parameter int FIFO_DEPTH  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         sample_in,
  input  logic                          sample_strobe,
  input  logic                          enable,
  input  logic [1:0]                    avg_sel,
  output logic [DATA_WIDTH-1:0]         dout,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          overflow_clr,
  output logic [COUNT_WIDTH-1:0]        sample_count
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int ACC_W = DATA_WIDTH + 3;

  logic [1:0]            r_avgSel;
  logic [ACC_W-1:0]      r_acc;
  logic [2:0]            r_avgCnt;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wrPtr;
  logic [AW-1:0]         r_rdPtr;
  logic [AW:0]           r_count;
  logic                  r_overflow;
  logic [COUNT_WIDTH-1:0] r_sampleCount;

  logic                  w_selChange;
  logic                  w_capture;
  logic [2:0]            w_lastIdx;
  logic                  w_final;
  logic [ACC_W-1:0]      w_sum;
  logic [DATA_WIDTH-1:0] w_result;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_accept;
  logic                  w_drop;
  logic [AW-1:0]         w_headIdx;

  // 3'd1 << 3 wraps to 0, so the last index for 8-word averaging comes out as 7.
  assign w_lastIdx   = (3'd1 << r_avgSel) - 3'd1;
  assign w_selChange = (avg_sel != r_avgSel);
  assign w_capture   = enable && sample_strobe && !w_selChange;
  assign w_final     = w_capture && (r_avgCnt == w_lastIdx);
  assign w_sum       = r_acc + ACC_W'(sample_in);
  assign w_result    = DATA_WIDTH'(w_sum >> r_avgSel);

  assign w_pop    = dout_valid && dout_ready;
  assign w_full   = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_accept = w_final && (!w_full || w_pop);
  assign w_drop   = w_final && w_full && !w_pop;

  // When empty, point at the slot just popped so dout holds its last value.
  assign w_headIdx  = (r_count == '0) ? (r_rdPtr - AW'(1)) : r_rdPtr;
  assign dout       = r_mem[w_headIdx];
  assign dout_valid = (r_count != '0);

  assign fifo_count   = r_count;
  assign overflow     = r_overflow;
  assign sample_count = r_sampleCount;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_avgSel <= '0;
      r_acc    <= '0;
      r_avgCnt <= '0;
    end else begin
      r_avgSel <= avg_sel;
      if (w_selChange || !enable || w_final) begin
        r_acc    <= '0;
        r_avgCnt <= '0;
      end else if (w_capture) begin
        r_acc    <= w_sum;
        r_avgCnt <= r_avgCnt + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wrPtr       <= '0;
      r_rdPtr       <= '0;
      r_count       <= '0;
      r_overflow    <= 1'b0;
      r_sampleCount <= '0;
    end else begin
      if (w_accept) begin
        r_mem[r_wrPtr] <= w_result;
        r_wrPtr        <= r_wrPtr + AW'(1);
        r_sampleCount  <= r_sampleCount + COUNT_WIDTH'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      if (w_accept && !w_pop) begin
        r_count <= r_count + (AW+1)'(1);
      end else if (w_pop && !w_accept) begin
        r_count <= r_count - (AW+1)'(1);
      end
      // A drop and a clear in the same cycle leave the flag set.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (overflow_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cic_sample_buffer.sv
// Scoreboard bench for cic_sample_buffer: stimulus pushes expected words,
// a negedge monitor pops and compares on every accepted handshake.
`timescale 1ns/1ps
module tb_cic_sample_buffer;

  localparam int DW = 25;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] sample_in;
  logic          sample_strobe;
  logic          enable;
  logic [1:0]    avg_sel;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic [3:0]    fifo_count;
  logic          overflow;
  logic          overflow_clr;
  logic [15:0]   sample_count;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] sb [$];

  cic_sample_buffer #(.DATA_WIDTH(25), .FIFO_DEPTH(8), .COUNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .sample_in(sample_in), .sample_strobe(sample_strobe),
    .enable(enable), .avg_sel(avg_sel), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .fifo_count(fifo_count), .overflow(overflow),
    .overflow_clr(overflow_clr), .sample_count(sample_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One strobe of value, then gap idle cycles; returns #1 after the last edge.
  task automatic applyStimulus(input logic [DW-1:0] value, input int gap);
    @(posedge clk); #1;
    sample_in     = value;
    sample_strobe = 1'b1;
    @(posedge clk); #1;
    sample_strobe = 1'b0;
    repeat (gap) @(posedge clk);
    if (gap > 0) #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every handshake must match the oldest expected word.
  always @(negedge clk) begin
    if (!reset && dout_valid && dout_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedWord: got 0x%0h, expected no word at %0t", dout, $time);
      end else begin
        checkOutput("doutScoreboard", 32'(dout), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; sample_in = '0; sample_strobe = 1'b0; enable = 1'b0;
    avg_sel = 2'd0; dout_ready = 1'b1; overflow_clr = 1'b0;
    idle(2);
    checkOutput("resetDout", 32'(dout), 32'h0);
    checkOutput("resetValid", 32'(dout_valid), 32'h0);
    checkOutput("resetCount", 32'(fifo_count), 32'h0);
    checkOutput("resetOverflow", 32'(overflow), 32'h0);
    checkOutput("resetSampleCount", 32'(sample_count), 32'h0);
    reset = 1'b0;
    enable = 1'b1;
    idle(2);

    // Pass-through with avg_sel=0 and the one-cycle latency.
    @(posedge clk); #1;
    sample_in = 25'h0000100; sample_strobe = 1'b1;
    sb.push_back(25'h0000100);
    #1 checkOutput("noBypassValid", 32'(dout_valid), 32'h0);
    @(posedge clk); #1;
    sample_strobe = 1'b0;
    checkOutput("latencyValid", 32'(dout_valid), 32'h1);
    checkOutput("latencyDout", 32'(dout), 32'h100);
    idle(255);
    sb.push_back(25'h1FFFFFF);
    applyStimulus(25'h1FFFFFF, 256);
    checkOutput("passSampleCount", 32'(sample_count), 32'd2);
    checkOutput("emptyHoldDout", 32'(dout), 32'h1FFFFFF);

    // Average of four: (10+11+12+14)>>2 = 11.
    avg_sel = 2'd2;
    idle(2);
    applyStimulus(25'd10, 0);
    applyStimulus(25'd11, 0);
    applyStimulus(25'd12, 0);
    checkOutput("avg4NoEarlyPush", 32'(dout_valid), 32'h0);
    sb.push_back(25'd11);
    applyStimulus(25'd14, 3);
    checkOutput("avg4SampleCount", 32'(sample_count), 32'd3);

    // Average of eight full-scale words must not overflow the accumulator.
    avg_sel = 2'd3;
    idle(2);
    for (int i = 0; i < 7; i++) applyStimulus(25'h1FFFFFF, 0);
    checkOutput("avg8NoEarlyPush", 32'(fifo_count), 32'h0);
    sb.push_back(25'h1FFFFFF);
    applyStimulus(25'h1FFFFFF, 3);

    // Fill past full with the consumer stalled.
    avg_sel = 2'd0;
    dout_ready = 1'b0;
    idle(2);
    for (int i = 0; i < 9; i++) begin
      if (i < 8) sb.push_back(25'(100 + i));
      applyStimulus(25'(100 + i), 0);
    end
    checkOutput("fullCount", 32'(fifo_count), 32'd8);
    checkOutput("fullOverflow", 32'(overflow), 32'h1);
    checkOutput("fullSampleCount", 32'(sample_count), 32'd12);
    checkOutput("fullHeadDout", 32'(dout), 32'd100);
    dout_ready = 1'b1;
    idle(10);
    checkOutput("drainValid", 32'(dout_valid), 32'h0);
    checkOutput("drainCount", 32'(fifo_count), 32'h0);
    checkOutput("drainHoldDout", 32'(dout), 32'd107);

    // Clear overflow, refill, then push coincident with a pop while full.
    overflow_clr = 1'b1;
    idle(1);
    overflow_clr = 1'b0;
    checkOutput("overflowCleared", 32'(overflow), 32'h0);
    dout_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sb.push_back(25'(200 + i));
      applyStimulus(25'(200 + i), 0);
    end
    @(posedge clk); #1;
    dout_ready = 1'b1; sample_in = 25'd300; sample_strobe = 1'b1;
    sb.push_back(25'd300);
    @(posedge clk); #1;
    dout_ready = 1'b0; sample_strobe = 1'b0;
    checkOutput("pushPopFullCount", 32'(fifo_count), 32'd8);
    checkOutput("pushPopFullOverflow", 32'(overflow), 32'h0);
    checkOutput("pushPopSampleCount", 32'(sample_count), 32'd21);

    // Overflow event and clear in the same cycle: set wins.
    @(posedge clk); #1;
    sample_in = 25'd400; sample_strobe = 1'b1; overflow_clr = 1'b1;
    @(posedge clk); #1;
    sample_strobe = 1'b0; overflow_clr = 1'b0;
    checkOutput("setWinsOverflow", 32'(overflow), 32'h1);
    checkOutput("dropSampleCount", 32'(sample_count), 32'd21);
    overflow_clr = 1'b1;
    idle(1);
    overflow_clr = 1'b0;
    dout_ready = 1'b1;
    idle(10);
    checkOutput("drain2Count", 32'(fifo_count), 32'h0);

    // Changing avg_sel discards a partial sum.
    avg_sel = 2'd2;
    idle(2);
    applyStimulus(25'd5, 0);
    applyStimulus(25'd6, 0);
    avg_sel = 2'd0;
    idle(2);
    sb.push_back(25'h123);
    applyStimulus(25'h123, 3);

    // Pulsing enable low discards a partial sum: (1+2+3+4)>>2 = 2.
    avg_sel = 2'd2;
    idle(2);
    applyStimulus(25'd7, 0);
    applyStimulus(25'd8, 0);
    enable = 1'b0;
    idle(1);
    enable = 1'b1;
    applyStimulus(25'd1, 0);
    applyStimulus(25'd2, 0);
    applyStimulus(25'd3, 0);
    checkOutput("enableNoEarlyPush", 32'(fifo_count), 32'h0);
    sb.push_back(25'd2);
    applyStimulus(25'd4, 3);

    // A strobe in the cycle avg_sel changes is dropped: (2+4)>>1 = 3.
    avg_sel = 2'd0;
    idle(2);
    @(posedge clk); #1;
    avg_sel = 2'd1; sample_in = 25'h50; sample_strobe = 1'b1;
    @(posedge clk); #1;
    sample_strobe = 1'b0;
    applyStimulus(25'd2, 0);
    sb.push_back(25'd3);
    applyStimulus(25'd4, 3);
    checkOutput("preResetSampleCount", 32'(sample_count), 32'd24);

    // Reset with words queued empties everything at once.
    avg_sel = 2'd0;
    dout_ready = 1'b0;
    idle(2);
    applyStimulus(25'hA, 0);
    applyStimulus(25'hB, 0);
    applyStimulus(25'hC, 0);
    checkOutput("queuedCount", 32'(fifo_count), 32'd3);
    #2 reset = 1'b1;
    #1;
    checkOutput("midResetValid", 32'(dout_valid), 32'h0);
    checkOutput("midResetCount", 32'(fifo_count), 32'h0);
    checkOutput("midResetDout", 32'(dout), 32'h0);
    checkOutput("midResetSampleCount", 32'(sample_count), 32'h0);
    idle(2);
    reset = 1'b0;
    idle(2);
    checkOutput("scoreboardDrained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
